// File: rtl/wm8731_config_seq.sv
// rtl/wm8731_config_seq.sv - WM8731 power-up register sequencer over the 2-wire control bus
module wm8731_config_seq #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] quart,
  input  logic [4:0] nbit,
  input  logic       start,
  input  logic       sda_in,
  output logic       sclk,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] idx
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {IDLE, ALIGN, FRAME, DONE, ERR} state_t;

  state_t        state;
  logic [1:0]    quart_q;
  logic          armed;
  logic          nack;
  logic [RW-1:0] retry;
  logic          tick;
  logic [23:0]   frame_word;
  logic [4:0]    bsel;
  logic          bus_sclk;
  logic          bus_oe;
  logic          ack_slot;

  // {addr[6:0], data[8:0]} for each table entry
  function automatic logic [15:0] reg_entry(input logic [3:0] i);
    case (i)
      4'd0:    reg_entry = {7'h0F, 9'h000};
      4'd1:    reg_entry = {7'h00, 9'h017};
      4'd2:    reg_entry = {7'h01, 9'h017};
      4'd3:    reg_entry = {7'h02, 9'h079};
      4'd4:    reg_entry = {7'h03, 9'h079};
      4'd5:    reg_entry = {7'h04, 9'h012};
      4'd6:    reg_entry = {7'h05, 9'h000};
      4'd7:    reg_entry = {7'h06, 9'h000};
      4'd8:    reg_entry = {7'h07, 9'h002};
      4'd9:    reg_entry = {7'h08, 9'h000};
      4'd10:   reg_entry = {7'h09, 9'h001};
      default: reg_entry = 16'h0000;
    endcase
  endfunction

  assign tick       = (quart != quart_q);
  assign frame_word = {DEV_ADDR, 1'b0, reg_entry(idx)};

  // Bus levels the current slot/quarter calls for
  always_comb begin
    bus_sclk = 1'b1;
    bus_oe   = 1'b0;
    ack_slot = 1'b0;
    bsel     = 5'd0;
    if (nbit == 5'd0) begin
      bus_oe = quart[1];
    end else if (nbit == 5'd28) begin
      bus_sclk = (quart != 2'd0);
      bus_oe   = ~quart[1];
    end else if (nbit < 5'd28) begin
      bus_sclk = quart[0] ^ quart[1];
      if (nbit == 5'd9 || nbit == 5'd18 || nbit == 5'd27) begin
        ack_slot = 1'b1;
      end else begin
        if (nbit < 5'd9)       bsel = 5'd24 - nbit;
        else if (nbit < 5'd18) bsel = 5'd25 - nbit;
        else                   bsel = 5'd26 - nbit;
        bus_oe = ~frame_word[bsel];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      quart_q <= 2'd0;
      armed   <= 1'b0;
      nack    <= 1'b0;
      retry   <= '0;
      sclk    <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      idx     <= 4'd0;
    end else begin
      quart_q <= quart;
      // Keeps a start that lands on the first clk out of reset from being taken
      armed   <= 1'b1;
      case (state)
        IDLE, DONE, ERR: begin
          if (start && armed) begin
            state <= ALIGN;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
            idx   <= 4'd0;
            retry <= '0;
          end
        end
        ALIGN: begin
          if (tick && nbit == 5'd0 && quart == 2'd0) begin
            state  <= FRAME;
            sclk   <= bus_sclk;
            sda_oe <= bus_oe;
            nack   <= 1'b0;
          end
        end
        FRAME: begin
          if (tick) begin
            sclk   <= bus_sclk;
            sda_oe <= bus_oe;
            if (nbit == 5'd0 && quart == 2'd0)
              nack <= 1'b0;
            else if (ack_slot && quart == 2'd2 && sda_in)
              nack <= 1'b1;
            if (nbit == 5'd31 && quart == 2'd3) begin
              if (!nack) begin
                if (idx == 4'd10) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  idx   <= idx + 4'd1;
                  retry <= '0;
                end
              end else if (retry < RW'(RETRY_MAX)) begin
                retry <= retry + 1'b1;
              end else begin
                state <= ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_config_seq.sv
// tb/tb_wm8731_config_seq.sv - directed bench: bus decoder, ack/nack slave, protocol checker
module tb_wm8731_config_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] quart = 2'd0;
  logic [4:0] nbit = 5'd0;
  logic       start = 1'b0;
  logic       sda_in;
  logic       sclk, sda_oe, busy, done, error;
  logic [3:0] idx;
  logic       slave_pull = 1'b0;

  assign sda_in = ~(sda_oe | slave_pull);

  wm8731_config_seq dut (
    .clk(clk), .reset(reset), .quart(quart), .nbit(nbit), .start(start), .sda_in(sda_in),
    .sclk(sclk), .sda_oe(sda_oe), .busy(busy), .done(done), .error(error), .idx(idx)
  );

  always #5 clk = ~clk;

  // Quarter counter: each quarter lasts two clks
  initial begin
    logic sub;
    sub = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sub = ~sub;
      if (!sub) {nbit, quart} = {nbit, quart} + 7'd1;
    end
  end

  typedef struct { logic [7:0] b1; logic [7:0] b2; } ent_t;
  typedef struct { string name; logic [63:0] mask; int frames; logic done; logic error; int idx; } scen_t;

  ent_t  tbl [11];
  scen_t scen[3];

  int checks = 0;
  int errors = 0;

  logic [7:0] fb0[256], fb1[256], fb2[256];
  int         fbn[256];
  int         frm_cnt = 0;
  int         base = 0;
  logic [63:0] nack_mask = '0;

  logic       psclk = 1'b1, psda = 1'b1, poe = 1'b0;
  logic [1:0] q1 = 2'd0, q2 = 2'd0;
  logic [4:0] nb1 = 5'd0;
  int         bitcnt = 0, bytecnt = 0;
  logic       in_frame = 1'b0, frame_nack = 1'b0;
  logic [7:0] shreg = 8'd0;
  logic [7:0] bytes[3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clk: sample at negedge, check bus protocol, decode frames, play the slave
  task automatic step();
    logic sda;
    int   k;
    @(negedge clk);
    sda = sda_in;
    if (reset) begin
      if (sclk !== psclk) begin
        checks++;
        if (q1 == q2) begin
          errors++;
          $display("FAIL sclk_glitch: sclk=%0b changed without a quarter tick (nbit %0d)", sclk, nb1);
        end
      end
      if (sda_oe !== poe) begin
        checks++;
        if (q1 == q2 || (sclk && !((nb1 == 5'd0 && sda_oe) || (nb1 == 5'd28 && !sda_oe)))) begin
          errors++;
          $display("FAIL sda_change: sda_oe=%0b with sclk=%0b at nbit %0d", sda_oe, sclk, nb1);
        end
      end
      if (psclk && sclk && psda && !sda) begin
        in_frame = 1'b1; bitcnt = 0; bytecnt = 0; slave_pull = 1'b0;
        k = frm_cnt - base;
        frame_nack = (k >= 0 && k < 64) ? nack_mask[k] : 1'b0;
      end else if (psclk && sclk && !psda && sda) begin
        if (in_frame && frm_cnt < 256) begin
          fb0[frm_cnt] = bytes[0]; fb1[frm_cnt] = bytes[1]; fb2[frm_cnt] = bytes[2];
          fbn[frm_cnt] = bytecnt;
          frm_cnt++;
        end
        in_frame = 1'b0; slave_pull = 1'b0;
      end else if (in_frame && !psclk && sclk) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], sda};
          bitcnt++;
        end else begin
          if (bytecnt < 3) bytes[bytecnt] = shreg;
          bytecnt++;
          bitcnt = 0;
        end
      end else if (in_frame && psclk && !sclk) begin
        slave_pull = (bitcnt == 8) && !(frame_nack && bytecnt == 0);
      end
    end else begin
      in_frame = 1'b0;
      slave_pull = 1'b0;
    end
    psclk = sclk; psda = sda_in; poe = sda_oe;
    q2 = q1; q1 = quart; nb1 = nbit;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait for the run to end, then compare flags and every logged frame against the model
  task automatic finish_scen(input scen_t sc);
    int n, got, e, r;
    n = 0;
    while (n < 20 * 256 && !(done || error)) begin
      step();
      n++;
    end
    check({sc.name, "_ended"}, int'(done || error), 1);
    if (done || error) check({sc.name, "_end_slot"}, int'({nbit, quart}), 127);
    repeat (4) step();
    check({sc.name, "_done"}, int'(done), int'(sc.done));
    check({sc.name, "_error"}, int'(error), int'(sc.error));
    check({sc.name, "_busy"}, int'(busy), 0);
    check({sc.name, "_idx"}, int'(idx), sc.idx);
    got = frm_cnt - base;
    check({sc.name, "_frames"}, got, sc.frames);
    e = 0; r = 0;
    for (int k = 0; k < sc.frames && k < got; k++) begin
      check($sformatf("%s_f%0d_nbytes", sc.name, k), fbn[base + k], 3);
      check($sformatf("%s_f%0d_dev", sc.name, k), int'(fb0[base + k]), 8'h34);
      check($sformatf("%s_f%0d_b1", sc.name, k), int'(fb1[base + k]), int'(tbl[e].b1));
      check($sformatf("%s_f%0d_b2", sc.name, k), int'(fb2[base + k]), int'(tbl[e].b2));
      if (!sc.mask[k]) begin
        if (e < 10) begin e++; r = 0; end
      end else if (r < 3) begin
        r++;
      end
    end
  endtask

  task automatic run_scen(input scen_t sc);
    base = frm_cnt;
    nack_mask = sc.mask;
    pulse_start();
    finish_scen(sc);
  endtask

  initial begin
    logic quiet;
    int   n;
    tbl[0]  = '{8'h1E, 8'h00}; tbl[1]  = '{8'h00, 8'h17}; tbl[2]  = '{8'h02, 8'h17};
    tbl[3]  = '{8'h04, 8'h79}; tbl[4]  = '{8'h06, 8'h79}; tbl[5]  = '{8'h08, 8'h12};
    tbl[6]  = '{8'h0A, 8'h00}; tbl[7]  = '{8'h0C, 8'h00}; tbl[8]  = '{8'h0E, 8'h02};
    tbl[9]  = '{8'h10, 8'h00}; tbl[10] = '{8'h12, 8'h01};
    scen[0] = '{"all_ack",   64'h0,                   11, 1'b1, 1'b0, 10};
    scen[1] = '{"nack_e3x2", 64'h18,                  13, 1'b1, 1'b0, 10};
    scen[2] = '{"nack_e0",   64'hFFFF_FFFF_FFFF_FFFF,  4, 1'b0, 1'b1, 0};

    repeat (5) step();
    check("rst_sclk", int'(sclk), 1);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_idx", int'(idx), 0);

    reset = 1'b1;
    pulse_start();
    repeat (3) step();
    check("start_at_reset_release_busy", int'(busy), 0);

    for (int s = 0; s < 3; s++) run_scen(scen[s]);

    // Mid-frame start waits for the frame boundary; a start while busy changes nothing
    n = 0;
    while (n < 400 && nbit != 5'd12) begin step(); n++; end
    check("wait_nbit12", int'(nbit), 12);
    base = frm_cnt;
    nack_mask = '0;
    pulse_start();
    check("mid_start_busy", int'(busy), 1);
    quiet = 1'b1;
    n = 0;
    while (n < 400 && !(nbit == 5'd0 && quart == 2'd0)) begin
      quiet = quiet && sclk && !sda_oe;
      step();
      n++;
    end
    check("mid_start_quiet", int'(quiet), 1);
    n = 0;
    while (n < 2000 && idx != 4'd2) begin step(); n++; end
    check("reach_idx2", int'(idx), 2);
    pulse_start();
    check("busy_start_idx", int'(idx), 2);
    finish_scen('{"mid_start", 64'h0, 11, 1'b1, 1'b0, 10});

    // Reset during slot 14 of the second frame releases the bus at once
    base = frm_cnt;
    nack_mask = '0;
    pulse_start();
    n = 0;
    while (n < 2000 && !((frm_cnt - base) >= 1 && nbit == 5'd14 && busy)) begin step(); n++; end
    check("reach_slot14", int'(nbit), 14);
    reset = 1'b0;
    #1;
    check("rstmid_sclk", int'(sclk), 1);
    check("rstmid_sda_oe", int'(sda_oe), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_idx", int'(idx), 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    run_scen('{"after_reset", 64'h0, 11, 1'b1, 1'b0, 10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
